// File: rtl/code_input_conditioner_pkg.sv
// Shared definitions for the code-entry button front end: arbitration
// states, button indices and the default debounce length.
package code_input_conditioner_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam int unsigned START = 0;
    localparam int unsigned RED   = 1;
    localparam int unsigned GREEN = 2;
    localparam int unsigned BLUE  = 3;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/code_input_conditioner_button_debouncer.sv
// Per-button conditioning: two-flop synchronizer, mismatch counter that
// flips the debounced level after DEBOUNCE_CYCLES consecutive mismatches,
// and a rise strobe derived from the debounced level.
module button_debouncer
    import code_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 10
) (
    input  logic Clk,
    input  logic Rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_prev;
    logic [CNT_W-1:0] cnt;

    // Synchronize, count consecutive mismatches and flip the level once the run is long enough.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            sync_q1    <= btn;
            sync_q2    <= sync_q1;
            level_prev <= level;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/code_input_conditioner.sv
// Front end for Code_Detector: debounces four buttons and arbitrates their
// rises into one-cycle, mutually exclusive pulses with a press lockout.
module code_input_conditioner
    import code_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 10
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Start_btn,
    input  logic Red_btn,
    input  logic Green_btn,
    input  logic Blue_btn,
    output logic Start,
    output logic Red,
    output logic Green,
    output logic Blue,
    output logic Conflict,
    output logic Held
);

    logic [3:0] btn_raw;
    logic [3:0] level;
    logic [3:0] rise;
    logic [2:0] colour_rise;
    logic       multi_colour;

    state_t state, state_nxt;
    logic   start_nxt, red_nxt, green_nxt, blue_nxt, conflict_nxt;

    assign btn_raw = {Blue_btn, Green_btn, Red_btn, Start_btn};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .Clk  (Clk),
            .Rst  (Rst),
            .btn  (btn_raw[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    assign colour_rise  = rise[BLUE:RED];
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_colour = |(colour_rise & (colour_rise - 3'd1));

    // Arbitration: Start always wins, colours only accepted from IDLE.
    always_comb begin
        state_nxt    = state;
        start_nxt    = 1'b0;
        red_nxt      = 1'b0;
        green_nxt    = 1'b0;
        blue_nxt     = 1'b0;
        conflict_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise[START]) begin
                    start_nxt = 1'b1;
                    state_nxt = HELD;
                end else if (colour_rise != 3'b000) begin
                    if (multi_colour) begin
                        conflict_nxt = 1'b1;
                    end else begin
                        red_nxt   = colour_rise[0];
                        green_nxt = colour_rise[1];
                        blue_nxt  = colour_rise[2];
                    end
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (rise[START]) begin
                    start_nxt = 1'b1;
                end else if (level == 4'b0000) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered output pulses.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            Start    <= 1'b0;
            Red      <= 1'b0;
            Green    <= 1'b0;
            Blue     <= 1'b0;
            Conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            Start    <= start_nxt;
            Red      <= red_nxt;
            Green    <= green_nxt;
            Blue     <= blue_nxt;
            Conflict <= conflict_nxt;
        end
    end

    assign Held = (state == HELD);

endmodule

// File: tb/tb_code_input_conditioner.sv
// Bench for code_input_conditioner with DEBOUNCE_CYCLES=4: every cycle's
// expected output vector {Start,Red,Green,Blue,Conflict,Held} is queued as
// stimulus is applied and compared just after the following clock edge.
module tb_code_input_conditioner;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_HELD  = 6'b000001;
    localparam logic [5:0] O_CONF  = 6'b000011;
    localparam logic [5:0] O_BLUE  = 6'b000101;
    localparam logic [5:0] O_GREEN = 6'b001001;
    localparam logic [5:0] O_RED   = 6'b010001;
    localparam logic [5:0] O_START = 6'b100001;

    logic Clk, Rst;
    logic Start_btn, Red_btn, Green_btn, Blue_btn;
    logic Start, Red, Green, Blue, Conflict, Held;

    logic [5:0] exp_q[$];
    int unsigned n_vec;
    int unsigned n_bad;

    code_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start_btn(Start_btn),
        .Red_btn  (Red_btn),
        .Green_btn(Green_btn),
        .Blue_btn (Blue_btn),
        .Start    (Start),
        .Red      (Red),
        .Green    (Green),
        .Blue     (Blue),
        .Conflict (Conflict),
        .Held     (Held)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (SRGBCH) at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue the expectation, advance one edge, then compare what the DUT shows.
    task automatic step(input string tag, input logic [5:0] exp);
        logic [5:0] e;
        exp_q.push_back(exp);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, {Start, Red, Green, Blue, Conflict, Held}, e);
    endtask

    task automatic run(input string tag, input int unsigned n, input logic [5:0] exp);
        for (int unsigned i = 0; i < n; i++) step(tag, exp);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        Rst = 1'b0;
        Start_btn = 1'b0;
        Red_btn   = 1'b1;
        Green_btn = 1'b0;
        Blue_btn  = 1'b0;

        // Reset with Red held, then release: pulse after edge 7.
        run("reset_hold", 5, O_NONE);
        Rst = 1'b1;
        run("rst_rel_wait", 6, O_NONE);
        step("rst_rel_red", O_RED);
        run("rst_rel_held", 3, O_HELD);
        Red_btn = 1'b0;
        run("rst_rel_fall", 6, O_HELD);
        step("rst_rel_idle", O_NONE);
        run("rst_rel_quiet", 2, O_NONE);

        // Clean Green press held 20 cycles.
        Green_btn = 1'b1;
        run("green_wait", 6, O_NONE);
        step("green_pulse", O_GREEN);
        run("green_held", 13, O_HELD);
        Green_btn = 1'b0;
        run("green_fall", 6, O_HELD);
        step("green_idle", O_NONE);
        run("green_quiet", 3, O_NONE);

        // Bouncing Blue never reaches DEBOUNCE_CYCLES consecutive mismatches.
        for (int unsigned r = 0; r < 5; r++) begin
            Blue_btn = 1'b1;
            run("bounce_hi", 3, O_NONE);
            Blue_btn = 1'b0;
            step("bounce_lo", O_NONE);
        end
        run("bounce_after", 6, O_NONE);

        // Red and Green together: Conflict only; Held until both released.
        Red_btn   = 1'b1;
        Green_btn = 1'b1;
        run("conf_wait", 6, O_NONE);
        step("conf_pulse", O_CONF);
        run("conf_held", 4, O_HELD);
        Red_btn = 1'b0;
        run("conf_one_left", 8, O_HELD);
        Green_btn = 1'b0;
        run("conf_fall", 6, O_HELD);
        step("conf_idle", O_NONE);
        run("conf_quiet", 2, O_NONE);

        // Single Blue press, released quickly after its pulse.
        Blue_btn = 1'b1;
        run("blue_wait", 6, O_NONE);
        step("blue_pulse", O_BLUE);
        Blue_btn = 1'b0;
        run("blue_fall", 6, O_HELD);
        step("blue_idle", O_NONE);

        // Lockout of Blue while Red held, then Start aborts.
        Red_btn = 1'b1;
        run("lock_wait", 6, O_NONE);
        step("lock_red", O_RED);
        run("lock_red_held", 10, O_HELD);
        Blue_btn = 1'b1;
        run("lock_blue_ign", 12, O_HELD);
        Start_btn = 1'b1;
        run("abort_wait", 6, O_HELD);
        step("abort_start", O_START);
        run("abort_held", 3, O_HELD);
        Start_btn = 1'b0;
        Red_btn   = 1'b0;
        Blue_btn  = 1'b0;
        run("lock_fall", 6, O_HELD);
        step("lock_idle", O_NONE);
        run("lock_quiet", 2, O_NONE);

        // Start and a colour on the same edge: Start wins, no Conflict.
        Start_btn = 1'b1;
        Blue_btn  = 1'b1;
        Red_btn   = 1'b1;
        run("sc_wait", 6, O_NONE);
        step("sc_start", O_START);
        run("sc_held", 2, O_HELD);
        Start_btn = 1'b0;
        Blue_btn  = 1'b0;
        Red_btn   = 1'b0;
        run("sc_fall", 6, O_HELD);
        step("sc_idle", O_NONE);
        run("sc_quiet", 2, O_NONE);

        // Reset during Red's debounce loses the partial count.
        Red_btn = 1'b1;
        run("mid_pre", 3, O_NONE);
        Rst = 1'b0;
        run("mid_rst", 3, O_NONE);
        Rst = 1'b1;
        run("mid_wait", 6, O_NONE);
        step("mid_red", O_RED);
        run("mid_held", 2, O_HELD);
        Red_btn = 1'b0;
        run("mid_fall", 6, O_HELD);
        step("mid_idle", O_NONE);
        run("mid_quiet", 3, O_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
